// File: rtl/instenc_loader.sv
// Packs field-level instruction requests into 16-bit Simple RISC Machine words,
// queues them in a small FIFO and writes them to consecutive memory addresses.
//
// state  | meaning
// S_IDLE | waiting for start; no requests accepted, no writes
// S_LOAD | accepting requests, draining FIFO into instruction memory
// S_DONE | one-cycle done pulse, then back to S_IDLE
module instenc_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        f_opcode,
    input  logic [1:0]        f_op,
    input  logic [2:0]        f_rn,
    input  logic [2:0]        f_rd,
    input  logic [2:0]        f_rm,
    input  logic [1:0]        f_shift,
    input  logic [7:0]        f_imm8,
    input  logic [4:0]        f_imm5,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic [ADDR_W:0]   count
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam logic [15:0] HALT_WORD = 16'hE000;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t state, state_nxt;

    logic [15:0]       enc_word;
    logic              enc_legal;
    logic              enc_is_halt;

    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty;
    logic [15:0]       head_word;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count_q;
    logic              err_illegal_q, err_ovf_q, halt_seen;

    logic              accept, push, pop, pop_halt, pop_ovf, addr_last;

    // Field packer; illegal encodings leave enc_legal low
    always_comb begin
        enc_word  = 16'h0000;
        enc_legal = 1'b0;
        case (f_opcode)
            3'b110: begin
                if (f_op == 2'b10) begin
                    enc_word  = {3'b110, 2'b10, f_rn, f_imm8};
                    enc_legal = 1'b1;
                end else if (f_op == 2'b00) begin
                    enc_word  = {3'b110, 2'b00, 3'b000, f_rd, f_shift, f_rm};
                    enc_legal = 1'b1;
                end
            end
            3'b101: begin
                enc_word  = {3'b101, f_op, f_rn, f_rd, f_shift, f_rm};
                enc_legal = 1'b1;
            end
            3'b011, 3'b100: begin
                enc_word  = {f_opcode, 2'b00, f_rn, f_rd, f_imm5};
                enc_legal = 1'b1;
            end
            3'b111: begin
                enc_word  = HALT_WORD;
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = 16'h0000;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign enc_is_halt = enc_legal && (f_opcode == 3'b111);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_word  = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign addr_last = (addr == {ADDR_W{1'b1}});
    assign accept    = (state == S_LOAD) && in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = mem_write && mem_ack;
    assign pop_halt  = pop && (head_word == HALT_WORD);
    // Last address consumed by a non-HALT word: stop rather than wrap
    assign pop_ovf   = pop && !pop_halt && addr_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (pop_halt || pop_ovf) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_LOAD: begin
                in_ready  = !fifo_full && !halt_seen;
                mem_write = !fifo_empty;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr    = addr;
    assign mem_wdata   = mem_write ? head_word : 16'h0000;
    assign count       = count_q;
    assign err_illegal = err_illegal_q;
    assign err_ovf     = err_ovf_q;

    always_ff @(posedge clk) begin
        if (push && !pop_ovf) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
        end
    end

    // Overflow flush wins over any push accepted in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (pop_ovf) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= '0;
            count_q       <= '0;
            err_illegal_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            halt_seen     <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                addr          <= base_addr;
                count_q       <= '0;
                err_illegal_q <= 1'b0;
                err_ovf_q     <= 1'b0;
                halt_seen     <= 1'b0;
            end
        end else if (state == S_LOAD) begin
            if (accept && !enc_legal) err_illegal_q <= 1'b1;
            if (accept && enc_is_halt) halt_seen <= 1'b1;
            if (pop) begin
                count_q <= count_q + (ADDR_W+1)'(1);
                if (!addr_last) addr <= addr + ADDR_W'(1);
            end
            if (pop_ovf) err_ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instenc_loader.sv
// Self-checking bench for instenc_loader: encoding table, hand-written corner
// sequences and randomized sessions checked against a field-level reference model.
module tb_instenc_loader;

    logic        clk = 1'b0;
    logic        reset_n, start, in_valid, in_ready, mem_ack;
    logic [7:0]  base_addr, mem_addr, f_imm8;
    logic [2:0]  f_opcode, f_rn, f_rd, f_rm;
    logic [1:0]  f_op, f_shift;
    logic [4:0]  f_imm5;
    logic        mem_write, busy, done, err_illegal, err_ovf;
    logic [15:0] mem_wdata;
    logic [8:0]  count;

    always #5 clk = ~clk;

    instenc_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .f_opcode(f_opcode), .f_op(f_op),
        .f_rn(f_rn), .f_rd(f_rd), .f_rm(f_rm), .f_shift(f_shift), .f_imm8(f_imm8),
        .f_imm5(f_imm5), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_ovf(err_ovf), .count(count)
    );

    typedef struct packed {
        logic [2:0]  opc;
        logic [1:0]  op;
        logic [2:0]  rn, rd, rm;
        logic [1:0]  sh;
        logic [7:0]  i8;
        logic [4:0]  i5;
        logic [15:0] word;
        logic        legal;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    int done_cnt = 0, stray_cnt = 0, stable_viol = 0;
    bit ack_rand = 0, chk_stable = 0, watch_stray = 0;
    logic [7:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    vec_t        req_q[$];

    logic        prev_hold = 1'b0;
    logic [7:0]  prev_a;
    logic [15:0] prev_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: a write is taken at the next rising edge when both are high
    always @(negedge clk) begin
        if (mem_write && mem_ack) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
        if (watch_stray && mem_write) stray_cnt++;
        if (chk_stable && prev_hold &&
            (!mem_write || mem_addr != prev_a || mem_wdata != prev_d)) stable_viol++;
        prev_hold = mem_write && !mem_ack;
        prev_a    = mem_addr;
        prev_d    = mem_wdata;
    end

    always @(posedge clk) begin
        #1;
        if (ack_rand) mem_ack = 1'($urandom_range(0, 1));
    end

    // Reference encoder written from the field layout with plain arithmetic
    function automatic vec_t mk_ref(int opc, int op, int rn, int rd, int rm, int sh, int i8, int i5);
        vec_t v;
        int   w;
        bit   ok;
        w  = 0;
        ok = 1;
        if (opc == 6 && op == 2)      w = 6*8192 + 2*2048 + rn*256 + i8;
        else if (opc == 6 && op == 0) w = 6*8192 + rd*32 + sh*8 + rm;
        else if (opc == 5)            w = 5*8192 + op*2048 + rn*256 + rd*32 + sh*8 + rm;
        else if (opc == 3 || opc == 4) w = opc*8192 + rn*256 + rd*32 + i5;
        else if (opc == 7)            w = 57344;
        else                          ok = 0;
        v = {3'(opc), 2'(op), 3'(rn), 3'(rd), 3'(rm), 2'(sh), 8'(i8), 5'(i5), 16'(w), ok};
        return v;
    endfunction

    function automatic vec_t mk(int opc, int op, int rn, int rd, int rm, int sh, int i8, int i5,
                                int word, bit legal);
        vec_t v;
        v = {3'(opc), 2'(op), 3'(rn), 3'(rd), 3'(rm), 2'(sh), 8'(i8), 5'(i5), 16'(word), legal};
        return v;
    endfunction

    task automatic start_session(input logic [7:0] b);
        @(posedge clk); #1;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int c;
        in_valid = 1'b1;
        f_opcode = v.opc; f_op = v.op; f_rn = v.rn; f_rd = v.rd; f_rm = v.rm;
        f_shift  = v.sh;  f_imm8 = v.i8; f_imm5 = v.i5;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) chk("send_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    endtask

    task automatic run_session(input logic [7:0] base, input string tag, input bit rnd);
        logic [7:0]  ea[$];
        logic [15:0] ed[$];
        bit          eill, eovf;
        int          a, n;
        eill = 0; eovf = 0; a = int'(base);
        foreach (req_q[i]) begin
            if (!req_q[i].legal) begin
                eill = 1;
                continue;
            end
            ea.push_back(8'(a));
            ed.push_back(req_q[i].word);
            if (req_q[i].word == 16'hE000) break;
            if (a == 255) begin
                eovf = 1;
                break;
            end
            a++;
        end
        wq_addr.delete(); wq_data.delete();
        done_cnt = 0; stable_viol = 0;
        chk_stable = rnd; ack_rand = rnd;
        if (!rnd) mem_ack = 1'b1;
        start_session(base);
        foreach (req_q[i]) send(req_q[i]);
        wait_done(tag);
        ack_rand = 0; chk_stable = 0;
        @(posedge clk); #2;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, wq_data.size(), ed.size());
        n = (wq_data.size() < ed.size()) ? wq_data.size() : ed.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), wq_data[i], ed[i]);
        end
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_count"}, count, ed.size());
        chk({tag, "_err_ill"}, err_illegal, eill);
        chk({tag, "_err_ovf"}, err_ovf, eovf);
        chk({tag, "_busy"}, busy, 0);
        if (rnd) chk({tag, "_hold_stable"}, stable_viol, 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t add_v, halt_v;
        int   accepts;

        reset_n = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; mem_ack = 1'b0;
        f_opcode = 3'd0; f_op = 2'd0; f_rn = 3'd0; f_rd = 3'd0; f_rm = 3'd0;
        f_shift = 2'd0; f_imm8 = 8'd0; f_imm5 = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_ill", err_illegal, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_count", count, 0);

        add_v  = mk(5, 0, 0, 2, 3, 0, 0, 0, 16'hA043, 1);
        halt_v = mk(7, 0, 0, 0, 0, 0, 0, 0, 16'hE000, 1);

        // Basic load
        req_q = '{mk(6, 2, 5, 0, 0, 0, 8'h55, 0, 16'hD555, 1),
                  mk(6, 0, 7, 1, 3, 1, 0, 0, 16'hC02B, 1),
                  add_v, halt_v};
        run_session(8'h10, "basic", 0);

        // Encoding table: fields, expected word, legality
        tbl.push_back(mk(5, 2, 6, 7, 5, 3, 0, 0, 16'hB6FD, 1));
        tbl.push_back(mk(5, 3, 1, 4, 2, 2, 0, 0, 16'hB992, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6, 2, 0, 3, 3, 3, 8'hFF, 7, 16'hD0FF, 1));
        tbl.push_back(mk(6, 0, 7, 7, 7, 3, 8'hAA, 0, 16'hC0FF, 1));
        tbl.push_back(mk(6, 1, 1, 2, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(3, 3, 2, 1, 0, 0, 0, 3, 16'h6223, 1));
        tbl.push_back(mk(4, 1, 2, 1, 5, 2, 8'h11, 3, 16'h8223, 1));
        tbl.push_back(mk(2, 3, 7, 7, 7, 3, 0, 0, 0, 0));
        tbl.push_back(mk(4, 0, 7, 7, 0, 0, 0, 31, 16'h87FF, 1));
        tbl.push_back(mk(6, 3, 4, 4, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7, 3, 7, 7, 7, 3, 8'hFF, 31, 16'hE000, 1));
        req_q = tbl;
        run_session(8'h40, "table", 0);

        // Immediate path
        req_q = '{mk(3, 3, 2, 1, 0, 0, 0, 3, 16'h6223, 1),
                  mk(4, 0, 2, 1, 0, 0, 0, 3, 16'h8223, 1), halt_v};
        run_session(8'h80, "imm", 0);

        // Illegal between two ADDs
        req_q = '{add_v, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), add_v, halt_v};
        run_session(8'h20, "illegal", 0);

        // Address space exhausted before HALT
        req_q = '{add_v, add_v, add_v};
        run_session(8'hFE, "ovf", 0);

        // Backpressure: no acks for 10 cycles while 6 requests are offered
        req_q = '{mk(6, 2, 5, 0, 0, 0, 8'h55, 0, 16'hD555, 1),
                  mk(6, 0, 7, 1, 3, 1, 0, 0, 16'hC02B, 1), add_v,
                  mk(5, 2, 6, 7, 5, 3, 0, 0, 16'hB6FD, 1),
                  mk(3, 3, 2, 1, 0, 0, 0, 3, 16'h6223, 1), halt_v};
        wq_addr.delete(); wq_data.delete(); done_cnt = 0;
        mem_ack = 1'b0;
        start_session(8'h10);
        fork
            foreach (req_q[i]) send(req_q[i]);
            begin
                accepts = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (in_valid && in_ready) accepts++;
                    if (mem_write) begin
                        chk("bp_hold_addr", mem_addr, 8'h10);
                        chk("bp_hold_data", mem_wdata, 16'hD555);
                    end
                end
                chk("bp_accepts", accepts, 4);
                chk("bp_ready_low", in_ready, 0);
                chk("bp_write_held", mem_write, 1);
                @(posedge clk); #1;
                mem_ack = 1'b1;
            end
        join
        wait_done("bp");
        repeat (3) @(negedge clk);
        chk("bp_nwrites", wq_data.size(), 6);
        for (int i = 0; i < 6 && i < wq_data.size(); i++) begin
            chk($sformatf("bp_addr%0d", i), wq_addr[i], 8'h10 + 8'(i));
            chk($sformatf("bp_data%0d", i), wq_data[i], req_q[i].word);
        end
        chk("bp_count", count, 6);

        // Reset in the middle of a session with two words queued
        mem_ack = 1'b0;
        start_session(8'h30);
        send(add_v);
        send(add_v);
        @(negedge clk);
        chk("mid_pre_write", mem_write, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_mem_write", mem_write, 0);
        chk("mid_mem_addr", mem_addr, 0);
        chk("mid_mem_wdata", mem_wdata, 0);
        chk("mid_busy", busy, 0);
        chk("mid_count", count, 0);
        chk("mid_in_ready", in_ready, 0);
        mem_ack = 1'b1;
        stray_cnt = 0; watch_stray = 1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        watch_stray = 0;
        chk("mid_no_write", stray_cnt, 0);
        chk("mid_idle_ready", in_ready, 0);

        // Randomized sessions against the reference model
        for (int s = 0; s < 8; s++) begin
            int n;
            req_q.delete();
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++)
                req_q.push_back(mk_ref($urandom_range(0, 6), $urandom_range(0, 3),
                                       $urandom_range(0, 7), $urandom_range(0, 7),
                                       $urandom_range(0, 7), $urandom_range(0, 3),
                                       $urandom_range(0, 255), $urandom_range(0, 31)));
            req_q.push_back(mk_ref(7, $urandom_range(0, 3), 0, 0, 0, 0, 0, 0));
            run_session(8'($urandom_range(0, 240)), $sformatf("rnd%0d", s), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
